// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-stage load/store engine: lane select, strobes, req/ack bus
//            handshake with timeout, and sign/zero-extended load writeback.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk_w_i,
    input  logic        rst_w_i_h,
    input  logic        start_w_i_h,
    input  logic        is_store_w_i_h,
    input  logic [2:0]  funct3_w_i,
    input  logic [31:0] addr_w_i,
    input  logic [31:0] store_data_w_i,
    output logic        busy_w_o_h,
    output logic        done_w_o_h,
    output logic        error_w_o_h,
    output logic [31:0] load_data_w_o,
    output logic        mem_req_w_o_h,
    output logic        mem_we_w_o_h,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_wdata_w_o,
    output logic [3:0]  mem_wstrb_w_o,
    input  logic        mem_ack_w_i_h,
    input  logic [31:0] mem_rdata_w_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last un-acked count before saturation; the cycle holding it is the final one.
    localparam logic [TIMEOUT_W-1:0] c_CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] c_CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [2:0]           r_funct3;
    logic [1:0]           r_off;
    logic [TIMEOUT_W-1:0] r_cnt;

    logic        w_illegal;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    always_comb begin
        w_illegal = (funct3_w_i == 3'b011) || (funct3_w_i[2:1] == 2'b11)
                 || ((funct3_w_i[1:0] == 2'b01) && addr_w_i[0])
                 || ((funct3_w_i[1:0] == 2'b10) && (addr_w_i[1:0] != 2'b00));
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (is_store_w_i_h) begin
            case (funct3_w_i[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << addr_w_i[1:0];
                    w_wdata = {4{store_data_w_i[7:0]}};
                end
                2'b01: begin
                    w_wstrb = addr_w_i[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{store_data_w_i[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = store_data_w_i;
                end
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata_w_i[7:0];
            2'd1:    w_byte = mem_rdata_w_i[15:8];
            2'd2:    w_byte = mem_rdata_w_i[23:16];
            default: w_byte = mem_rdata_w_i[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata_w_i[31:16] : mem_rdata_w_i[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_rdata_w_i;
        endcase
    end

    always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
        if (rst_w_i_h) begin
            r_state       <= S_IDLE;
            r_funct3      <= 3'b000;
            r_off         <= 2'b00;
            r_cnt         <= '0;
            busy_w_o_h    <= 1'b0;
            done_w_o_h    <= 1'b0;
            error_w_o_h   <= 1'b0;
            load_data_w_o <= 32'h0;
            mem_req_w_o_h <= 1'b0;
            mem_we_w_o_h  <= 1'b0;
            mem_addr_w_o  <= 32'h0;
            mem_wdata_w_o <= 32'h0;
            mem_wstrb_w_o <= 4'b0000;
        end else begin
            done_w_o_h <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_w_i_h) begin
                        busy_w_o_h <= 1'b1;
                        if (w_illegal) begin
                            r_state     <= S_DONE;
                            done_w_o_h  <= 1'b1;
                            error_w_o_h <= 1'b1;
                        end else begin
                            r_state       <= S_REQ;
                            error_w_o_h   <= 1'b0;
                            r_funct3      <= funct3_w_i;
                            r_off         <= addr_w_i[1:0];
                            r_cnt         <= '0;
                            mem_req_w_o_h <= 1'b1;
                            mem_we_w_o_h  <= is_store_w_i_h;
                            mem_addr_w_o  <= {addr_w_i[31:2], 2'b00};
                            mem_wdata_w_o <= w_wdata;
                            mem_wstrb_w_o <= w_wstrb;
                        end
                    end
                end
                S_REQ: begin
                    // Ack outranks a simultaneous timeout.
                    if (mem_ack_w_i_h || (r_cnt == c_CNT_LAST)) begin
                        r_state       <= S_DONE;
                        done_w_o_h    <= 1'b1;
                        error_w_o_h   <= !mem_ack_w_i_h;
                        mem_req_w_o_h <= 1'b0;
                        mem_we_w_o_h  <= 1'b0;
                        mem_wstrb_w_o <= 4'b0000;
                        if (mem_ack_w_i_h && !mem_we_w_o_h) begin
                            load_data_w_o <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    busy_w_o_h <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench with a completion scoreboard.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_store, ack;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    logic        busy, done, err, req, we;
    logic [31:0] ldata, maddr, wdata;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_W(4)) u_dut (
        .clk_w_i        (clk),
        .rst_w_i_h      (rst),
        .start_w_i_h    (start),
        .is_store_w_i_h (is_store),
        .funct3_w_i     (f3),
        .addr_w_i       (addr),
        .store_data_w_i (sdata),
        .busy_w_o_h     (busy),
        .done_w_o_h     (done),
        .error_w_o_h    (err),
        .load_data_w_o  (ldata),
        .mem_req_w_o_h  (req),
        .mem_we_w_o_h   (we),
        .mem_addr_w_o   (maddr),
        .mem_wdata_w_o  (wdata),
        .mem_wstrb_w_o  (wstrb),
        .mem_ack_w_i_h  (ack),
        .mem_rdata_w_i  (rdata)
    );

    typedef struct packed {
        logic        e_err;
        logic [31:0] e_data;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_req_rise = 0;

    always @(posedge req) n_req_rise++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start for a single cycle and queue its expected completion.
    task automatic launch(input logic st, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] d, input logic e_err, input logic [31:0] e_data);
        exp_t e;
        is_store = st; f3 = fn; addr = a; sdata = d; start = 1'b1;
        e.e_err = e_err; e.e_data = e_data;
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        chk({tag, "_sbq"}, {31'h0, (sb.size() != 0)}, 32'h1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_err"}, {31'h0, err}, {31'h0, e.e_err});
            chk({tag, "_ldata"}, ldata, e.e_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int rise0;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; ack = 1'b0;
        f3 = 3'b000; addr = 32'h0; sdata = 32'h0; rdata = 32'h0;
        tick(); tick();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done_err", {30'h0, done, err}, 32'h0);
        chk("rst_req_we_strb", {26'h0, req, we, wstrb}, 32'h0);
        chk("rst_addr", maddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_ldata", ldata, 32'h0);
        rst = 1'b0;
        tick();

        // LB 0x1003, zero-wait ack
        launch(1'b0, 3'b000, 32'h0000_1003, 32'h0, 1'b0, 32'hFFFF_FF80);
        chk("lb_req", {31'h0, req}, 32'h1);
        chk("lb_addr", maddr, 32'h0000_1000);
        chk("lb_strb_we", {27'h0, we, wstrb}, 32'h0);
        ack = 1'b1; rdata = 32'h80FF_1234;
        tick();
        ack = 1'b0;
        check_done("lb");
        chk("lb_req_drop", {31'h0, req}, 32'h0);
        tick();
        chk("lb_idle", {31'h0, busy}, 32'h0);

        // SH 0x2002, three wait states; accepted immediately in cycle 3
        launch(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 32'hFFFF_FF80);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (req !== 1'b1 || we !== 1'b1 || wstrb !== 4'b1100 ||
                wdata !== 32'hBEEF_BEEF || maddr !== 32'h0000_2000) bad++;
            if (i == 3) ack = 1'b1;
            tick();
        end
        ack = 1'b0;
        chk("sh_bus_stable", bad, 0);
        check_done("sh");
        tick();

        // SB 0x3001 lane 1
        launch(1'b1, 3'b000, 32'h0000_3001, 32'h1234_5678, 1'b0, 32'hFFFF_FF80);
        chk("sb_strb", {28'h0, wstrb}, 32'h2);
        chk("sb_wdata", wdata, 32'h7878_7878);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_done("sb");
        tick();

        // LW misaligned: error in cycle 1, no bus request
        rise0 = n_req_rise;
        launch(1'b0, 3'b010, 32'h0000_0001, 32'h0, 1'b1, 32'hFFFF_FF80);
        chk("lw_mis_req", {31'h0, req}, 32'h0);
        check_done("lw_mis");
        tick();
        chk("lw_mis_rises", n_req_rise - rise0, 0);
        chk("lw_mis_busy", {31'h0, busy}, 32'h0);

        // LHU 0x0002 with a stray start during REQ
        rise0 = n_req_rise;
        launch(1'b0, 3'b101, 32'h0000_0002, 32'h0, 1'b0, 32'h0000_F00D);
        start = 1'b1; f3 = 3'b010; addr = 32'h0000_0040;
        tick();
        start = 1'b0;
        chk("lhu_addr_kept", maddr, 32'h0);
        ack = 1'b1; rdata = 32'hF00D_0000;
        tick();
        ack = 1'b0;
        check_done("lhu");
        tick(); tick();
        chk("lhu_one_txn", n_req_rise - rise0, 1);
        chk("lhu_idle_req", {31'h0, req}, 32'h0);

        // LH 0x0000 sign-extend
        launch(1'b0, 3'b001, 32'h0000_0000, 32'h0, 1'b0, 32'hFFFF_8001);
        ack = 1'b1; rdata = 32'h1234_8001;
        tick();
        ack = 1'b0;
        check_done("lh");
        tick();

        // Timeout: 15 un-acked request cycles
        launch(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1, 32'hFFFF_8001);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (req !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        chk("to_req_cycles", bad, 0);
        check_done("to");
        chk("to_req_drop", {31'h0, req}, 32'h0);
        tick();

        // Ack coincides with saturation: success
        launch(1'b0, 3'b010, 32'h0000_0020, 32'h0, 1'b0, 32'hCAFE_F00D);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin
                ack = 1'b1; rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        ack = 1'b0;
        check_done("to_ack");
        tick();

        // Reset during REQ: immediate drop, late ack ignored
        is_store = 1'b0; f3 = 3'b010; addr = 32'h0000_0030; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rr_req_before", {31'h0, req}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rr_req_busy", {30'h0, req, busy}, 32'h0);
        #2 rst = 1'b0;
        ack = 1'b1; rdata = 32'h5555_5555;
        tick();
        ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        chk("rr_no_done", bad, 0);
        chk("rr_ldata", ldata, 32'h0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit in the memory stage, directly downstream of the ALU. It consumes the ALU result as the effective address, together with the rs2 store data and funct3. It runs a request/acknowledge transaction on the data-memory bus and returns a sign- or zero-extended load result, or an error flag, to writeback. Lane selection and strobe generation for byte, half and word accesses are done here.

## Interface
Parameters:
- TIMEOUT_W, 8: width of the bus-timeout counter; timeout fires after 2^TIMEOUT_W-1 un-acked request cycles.

Ports (one clock; reset is asynchronous and active-high):
- clk_w_i  input  1  clock, rising edge.
- rst_w_i_h  input  1  asynchronous, active-high reset.
- start_w_i_h  input  1  begin access; sampled only in IDLE.
- is_store_w_i_h  input  1  1 = store, 0 = load.
- funct3_w_i  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_w_i  input  32  effective address (ALU alu_res_w_o).
- store_data_w_i  input  32  rs2 value.
- busy_w_o_h  output  1  high in every state except IDLE.
- done_w_o_h  output  1  one-cycle completion pulse.
- error_w_o_h  output  1  valid with done; misaligned, illegal funct3, or timeout.
- load_data_w_o  output  32  extended load result; held until next done.
- mem_req_w_o_h  output  1  bus request.
- mem_we_w_o_h  output  1  bus write enable.
- mem_addr_w_o  output  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata_w_o  output  32  lane-replicated store data.
- mem_wstrb_w_o  output  4  byte strobes; 0000 on loads.
- mem_ack_w_i_h  input  1  bus acknowledge; mem_rdata valid in the same cycle.
- mem_rdata_w_i  input  32  read data.

## Operation
- States: IDLE, REQ, DONE.
- IDLE to REQ: start_w_i_h=1 and the access is legal. Capture is_store, funct3, addr[1:0], address, data and strobes into registers.
- IDLE to DONE: start_w_i_h=1 and the access is illegal. Set error=1; no bus request is issued.
- REQ to DONE: on mem_ack_w_i_h=1, or when the timeout counter saturates (error=1).
- DONE to IDLE: always, after 1 cycle.
- Illegal access: funct3 is 011, 110 or 111; or funct3 is 11x on a store; or H/HU with addr[0]=1; or W with addr[1:0]!=00.
- Store byte (SB): wstrb = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
- Store half (SH): wstrb = 0011 when addr[1]=0, 1100 when addr[1]=1; wdata = {2{data[15:0]}}.
- Store word (SW): wstrb = 1111; wdata = data.
- Load: select the byte or half lane by the captured addr[1:0].
  - LB/LH sign-extend from bit 7 or bit 15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - load_data_w_o updates only on a successful load completion.
- Store completion: load_data_w_o is unchanged.
- Error completion: load_data_w_o is unchanged.
- start_w_i_h while busy is ignored.
- mem_ack_w_i_h outside REQ is ignored.
- Timeout counter: clears on entry to REQ and increments each REQ cycle without ack. An ack arriving in the same cycle as saturation wins: the access completes with no error.

## Timing
- Reset (async, immediate): state=IDLE; mem_req=0, mem_we=0, wstrb=0; mem_addr=0, wdata=0; done=0, error=0, busy=0; load_data=0.
- All outputs are registered; none depends combinationally on inputs.
- Cycle 0: start sampled. Cycle 1: mem_req=1 with all bus fields stable.
- mem_req, mem_addr, mem_wdata, mem_wstrb and mem_we hold constant until ack is sampled.
- Ack sampled in cycle N: mem_req=0 in cycle N+1, with done=1 and load_data valid in N+1.
- Zero-wait-state bus (ack in cycle 1): done in cycle 2; next start is accepted in cycle 3.
- Illegal access: done=1 and error=1 in cycle 1; mem_req never rises.
- Timeout: done=1 and error=1 in the cycle after saturation; mem_req drops at the same time.
- Reset mid-REQ: mem_req drops immediately, with no done pulse. Any later ack is ignored.

## Test plan
- LB at addr 0x1003 with rdata 0x80FF_1234 and ack one cycle after req: mem_addr=0x1000, wstrb=0000, load_data=0xFFFF_FF80, done in cycle 2, error=0.
- SH at addr 0x2002 with data 0x0000_BEEF and ack after 3 wait cycles: wstrb=1100, wdata=0xBEEF_BEEF, bus fields stable for all 4 req cycles, load_data unchanged.
- LW at addr 0x0001: done=1 and error=1 in cycle 1; mem_req stays 0 throughout.
- LHU at addr 0x0002 with rdata 0xF00D_0000: load_data=0x0000_F00D. A start pulsed during REQ is ignored (exactly one bus transaction).
- Ack never asserted with TIMEOUT_W=4: done=1 and error=1 after 15 req cycles. A variant with ack in the saturation cycle completes with error=0.
- Assert rst_w_i_h mid-REQ: mem_req=0 and busy=0 within the same cycle. A later ack produces no done pulse.
